// File: rtl/game_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : game_round_ctrl                                              |
// | Description : Round sequencer for a timed game. It runs a READY countdown  |
// |               in seconds, then a PLAY phase counted in ms ticks, and ends  |
// |               in OVER. Optional pause support is built when the macro      |
// |               GAME_PAUSE_EN is defined.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module game_round_ctrl #(
    parameter int ROUND_MS    = 30000,
    parameter int READY_S     = 3,
    parameter int TICKS_PER_S = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_tick,
    input  logic        i_start,
    input  logic        i_pause,
    input  logic        i_abort,
    output logic        o_tmr_en,
    output logic        o_tmr_clr,
    output logic [2:0]  o_phase,
    output logic [15:0] o_remain_ms,
    output logic [1:0]  o_countdown,
    output logic        o_time_up
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } phase_t;

    localparam logic [15:0] ROUND_LD = 16'(ROUND_MS);
    localparam logic [1:0]  READY_LD = 2'(READY_S);
    localparam logic [9:0]  SUB_LD   = 10'(TICKS_PER_S - 1);

    phase_t      phase;
    phase_t      phase_nxt;
    logic [15:0] remain_nxt;
    logic [1:0]  countdown_nxt;
    logic [9:0]  sub;
    logic [9:0]  sub_nxt;
    logic        tmr_clr_nxt;
    logic        time_up_nxt;
    logic        tmr_en_nxt;

`ifndef GAME_PAUSE_EN
    // The pause request has no effect in this build.
    logic unused_pause;
    assign unused_pause = i_pause;
`endif

    assign o_phase = phase;

    // State and output registers; reset forces everything idle at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase       <= IDLE;
            o_remain_ms <= 16'd0;
            o_countdown <= 2'd0;
            sub         <= 10'd0;
            o_tmr_en    <= 1'b0;
            o_tmr_clr   <= 1'b0;
            o_time_up   <= 1'b0;
        end else begin
            phase       <= phase_nxt;
            o_remain_ms <= remain_nxt;
            o_countdown <= countdown_nxt;
            sub         <= sub_nxt;
            o_tmr_en    <= tmr_en_nxt;
            o_tmr_clr   <= tmr_clr_nxt;
            o_time_up   <= time_up_nxt;
        end
    end

    // Next-phase and next-output computation; abort overrides everything.
    always_comb begin
        phase_nxt     = phase;
        remain_nxt    = o_remain_ms;
        countdown_nxt = o_countdown;
        sub_nxt       = sub;
        tmr_clr_nxt   = 1'b0;
        time_up_nxt   = 1'b0;

        if (i_abort) begin
            phase_nxt     = IDLE;
            remain_nxt    = 16'd0;
            countdown_nxt = 2'd0;
            sub_nxt       = 10'd0;
            tmr_clr_nxt   = 1'b1;
        end else begin
            case (phase)
                IDLE, OVER: begin
                    if (i_start) begin
                        phase_nxt     = READY;
                        countdown_nxt = READY_LD;
                        sub_nxt       = SUB_LD;
                        tmr_clr_nxt   = 1'b1;
                    end
                end
                READY: begin
                    if (i_tick) begin
                        if (sub != 10'd0) begin
                            sub_nxt = sub - 10'd1;
                        end else if (o_countdown == 2'd1) begin
                            // Last tick of the final second starts play.
                            phase_nxt     = PLAY;
                            remain_nxt    = ROUND_LD;
                            countdown_nxt = 2'd0;
                            tmr_clr_nxt   = 1'b1;
                        end else begin
                            sub_nxt       = SUB_LD;
                            countdown_nxt = o_countdown - 2'd1;
                        end
                    end
                end
                PLAY: begin
                    if (i_tick && (o_remain_ms != 16'd0)) begin
                        remain_nxt = o_remain_ms - 16'd1;
                        if (o_remain_ms == 16'd1) begin
                            phase_nxt   = OVER;
                            time_up_nxt = 1'b1;
                        end
                    end
`ifdef GAME_PAUSE_EN
                    // Expiry in the same cycle takes precedence over pausing.
                    if (i_pause && !time_up_nxt) begin
                        phase_nxt = PAUSE;
                    end
`endif
                end
`ifdef GAME_PAUSE_EN
                PAUSE: begin
                    if (i_pause) begin
                        phase_nxt = PLAY;
                    end
                end
`endif
                default: begin
                    phase_nxt = IDLE;
                end
            endcase
        end

        tmr_en_nxt = (phase_nxt == READY) || (phase_nxt == PLAY);
    end

endmodule
`default_nettype wire

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 SHALL have parameter ROUND_MS, default 30000, play-phase length in ms ticks; legal range 1..65535.
REQ-002 SHALL have parameter READY_S, default 3, pre-play countdown length in seconds; legal range 1..3.
REQ-003 SHALL have parameter TICKS_PER_S, default 1000, i_tick pulses per countdown second; legal range 1..1000; reduced values are for simulation only.
REQ-004 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_tick  input  1  1 ms tick from the game timer, one clk wide.
REQ-007 SHALL have port i_start  input  1  start/restart request, one-cycle pulse.
REQ-008 SHALL have port i_pause  input  1  pause-toggle request, one-cycle pulse.
REQ-009 SHALL have port i_abort  input  1  return-to-idle request, one-cycle pulse.
REQ-010 SHALL have port o_tmr_en  output  1  game timer count enable.
REQ-011 SHALL have port o_tmr_clr  output  1  game timer clear, one-cycle pulse.
REQ-012 SHALL have port o_phase  output  3  0=IDLE, 1=READY, 2=PLAY, 3=PAUSE, 4=OVER.
REQ-013 SHALL have port o_remain_ms  output  16  ms remaining in the round.
REQ-014 SHALL have port o_countdown  output  2  READY seconds digit (READY_S..1); 0 outside READY.
REQ-015 SHALL have port o_time_up  output  1  one-cycle pulse at round expiry.

Function
REQ-016 SHALL register all outputs; every response appears on the clk edge after the causing input cycle.
REQ-017 IDLE + i_start SHALL go to READY, pulse o_tmr_clr, load o_countdown=READY_S, and load the sub-second counter=TICKS_PER_S-1.
REQ-018 In READY, each i_tick SHALL decrement the sub-second counter; a tick with the sub-counter at 0 SHALL reload it to TICKS_PER_S-1 and decrement o_countdown.
REQ-019 A READY tick with o_countdown=1 and sub-counter=0 SHALL enter PLAY, load o_remain_ms=ROUND_MS, set o_countdown=0, and pulse o_tmr_clr.
REQ-020 In PLAY, each i_tick SHALL decrement o_remain_ms by 1; the tick taking it from 1 to 0 SHALL enter OVER and assert o_time_up in that same cycle.
REQ-021 o_remain_ms SHALL never wrap below 0; ticks in IDLE, PAUSE and OVER SHALL be ignored.
REQ-022 o_tmr_en SHALL be 1 exactly in READY and PLAY.
REQ-023 OVER + i_start SHALL behave as IDLE + i_start; o_remain_ms holds 0 until then.
REQ-024 i_start in READY, PLAY or PAUSE SHALL be ignored.
REQ-025 i_abort SHALL win over all other inputs and, from any phase, SHALL go to IDLE with o_remain_ms=0, o_countdown=0 and o_tmr_clr pulsed.
REQ-026 PLAY with i_tick and i_pause in the same cycle SHALL both apply the decrement and enter PAUSE; if that decrement expires the round, OVER takes priority.

Reset
REQ-027 rst low SHALL immediately force phase=IDLE, o_remain_ms=0, o_countdown=0, sub-counter=0, o_tmr_en=0, o_tmr_clr=0 and o_time_up=0, including mid-round.
REQ-028 After rst deasserts, the block SHALL stay in IDLE until i_start.

Configuration
REQ-029 With GAME_PAUSE_EN defined, PLAY + i_pause SHALL enter PAUSE and PAUSE + i_pause SHALL return to PLAY, with o_remain_ms frozen during PAUSE.
REQ-030 Without GAME_PAUSE_EN, i_pause SHALL be ignored, PAUSE SHALL be unreachable and o_phase SHALL never equal 3.

Verification
REQ-031 Reset release, no inputs for 100 clk -> o_phase=0, all outputs 0.
REQ-032 TICKS_PER_S=4, READY_S=2, ROUND_MS=5, i_start then ticks -> o_countdown 2,1; PLAY after the 8th tick with o_remain_ms=5; OVER plus one o_time_up pulse on the 13th tick; o_tmr_clr pulsed twice.
REQ-033 GAME_PAUSE_EN, PLAY at o_remain_ms=3, i_pause, 10 ticks, i_pause, 1 tick -> phase 3 with remain held at 3, then phase 2 with remain 2.
REQ-034 PLAY at remain=1, i_tick and i_pause in the same cycle -> phase 4, o_time_up=1, remain=0.
REQ-035 i_abort during READY and during PLAY -> phase 0 next cycle, remain 0, o_tmr_clr pulse; i_start in PLAY -> no change.
REQ-036 rst asserted mid-PLAY (remain=3) -> immediate phase 0, o_tmr_en=0; no o_time_up pulse.
